checkers_board_state: RTL and testbench
=======================================

# checkers_board_state

Owns the 64-square checkers board and the turn, applies one move request at a time, and presents the packed 192-bit board consumed by the board drawer. Sits between the input/controller logic, which issues from/to moves, and the drawer, which reads `board` continuously. Validates geometry, ownership and captures, clears captured pieces, promotes kings, and pulses `board_update` so the frame can be redrawn.

## Interface
- No parameters; board is fixed at 8x8, 3 bits per square.
- Reset and clock (already decided): reset `rst`, asynchronous, active-low; clock `clk`.
- `clk` in 1 — system clock.
- `rst` in 1 — async active-low reset.
- `new_game` in 1 — sync reload of the initial layout.
- `move_valid` in 1 — move request present.
- `move_ready` out 1 — block can accept; high only in IDLE.
- `move_from` in 6 — source square, index = row*8+col.
- `move_to` in 6 — destination square.
- `move_done` out 1 — one-cycle pulse at end of every accepted request.
- `move_ok` out 1 — valid with `move_done`; 1 = move applied.
- `move_err` out 3 — valid with `move_done`; 0 ok, 1 bad source, 2 destination occupied, 3 illegal geometry, 4 no piece to capture.
- `turn` out 1 — 0 = player 1 to move, 1 = player 2.
- `board` out 192 — square i at bits [3i+2:3i].
- `board_update` out 1 — one-cycle pulse whenever `board` changed.

## Operation
- Square codes: 000 light, non-playable; 111 empty dark square; 001 P1 man; 010 P2 man; 101 P1 king; 110 P2 king.
- Dark squares are those where (row+col) is odd.
- Initial layout: dark squares in rows 0-2 hold 001, rows 5-7 hold 010, rows 3-4 hold 111; all light squares hold 000.
- P1 men move toward increasing row and promote on row 7. P2 men move toward decreasing row and promote on row 0. Kings move in either direction.
- Deltas use signed 4-bit math on the 3-bit row and column separately. Row wrap and column wrap are therefore never legal.
- Source must hold the current player's man or king, else error 1.
- Destination must be 111, else error 2. A light-square destination (000) also gives error 2.
- Simple move: |dr|=|dc|=1 with a legal direction.
- Jump: |dr|=|dc|=2 with a legal direction. The mid square (average of from and to) must hold an opponent piece, else error 4.
- Any other delta, or a wrong direction for a man, gives error 3.
- Errors are checked in the order 1, 2, 3, 4; the first failure is reported.
- On success:
  - source becomes 111;
  - mid square becomes 111 on a jump;
  - destination gets the moving piece, promoted (001→101, 010→110) on the far row;
  - `turn` toggles.
- A failed move leaves `board` and `turn` unchanged.
- Not enforced: forced capture and multi-jump continuation. Each jump is a separate request.

## Timing
- FSM states and transitions:
  - IDLE → READ when `move_valid` is high.
  - READ: latch the from, to and mid square codes.
  - CHECK: compute `move_err`.
  - WRITE: update board and turn if ok; no change on error.
  - DONE: `move_done` pulse → IDLE.
- Fixed latency: accept edge at cycle t, `move_done` high during cycle t+4. `board_update` is high in the same cycle when ok.
- `move_ready` = (state==IDLE). `move_valid` without `move_ready` is ignored; the requester holds until accepted.
- `move_from` and `move_to` are sampled only at the accept edge.
- `new_game` takes priority in every state:
  - next cycle: initial board, `turn`=0, IDLE;
  - `board_update` pulses;
  - an in-flight move is aborted with no `move_done`.
- `new_game` together with `move_valid` in IDLE: the move is not accepted.
- Reset values: board = initial layout, `turn`=0, state IDLE (`move_ready`=1), `move_done`=0, `move_ok`=0, `move_err`=0, `board_update`=0.
- Reset mid-operation discards the move.
- `move_ok` and `move_err` hold their values until the next `move_done`.

## Structure
- Package `checkers_pkg` holds:
  - square-code constants;
  - error-code constants;
  - FSM state encoding;
  - `INIT_BOARD` 192-bit constant;
  - a square-slice helper function.
- Sub-module `checkers_move_rules` (combinational): from/to codes, mid code, from/to coordinates and turn → error code, jump flag, promoted destination code.

## Test plan
- Reset → `board`==`INIT_BOARD`, `turn`=0, `move_ready`=1; square 17 (r2,c1)=001, square 24 (r3,c0)=111.
- P1 move 17→24 → `move_done` at t+4 with `move_ok`=1; sq17=111, sq24=001, `turn`=1, `board_update` pulse.
- P2 move 40→33, then P1 move 24→33 → second move has `move_err`=2. Then P1 jump 24→42 with sq33=010 and sq42=111 → sq33=111, sq42=001.
- P2 attempts to move a P1 piece (from=17) → `move_err`=1. Man moving backward → error 3. Jump over an empty square → error 4. Board unchanged in all three cases.
- P1 man moves onto row 7 → destination=101. A king then moves backward → `move_ok`=1.
- `new_game` asserted during CHECK → no `move_done`, `board`==`INIT_BOARD`, `turn`=0, `board_update` pulse. Async `rst` mid-WRITE → reset values.

Source files
------------

// File: rtl/checkers_pkg.sv
// Shared definitions for the checkers board slice: square and error codes,
// move FSM encoding, the opening layout and square-addressing helpers.
package checkers_pkg;

    localparam logic [2:0] SQ_LIGHT   = 3'b000;
    localparam logic [2:0] SQ_P1_MAN  = 3'b001;
    localparam logic [2:0] SQ_P2_MAN  = 3'b010;
    localparam logic [2:0] SQ_P1_KING = 3'b101;
    localparam logic [2:0] SQ_P2_KING = 3'b110;
    localparam logic [2:0] SQ_EMPTY   = 3'b111;

    localparam logic [2:0] ERR_OK   = 3'd0;
    localparam logic [2:0] ERR_SRC  = 3'd1;
    localparam logic [2:0] ERR_DST  = 3'd2;
    localparam logic [2:0] ERR_GEOM = 3'd3;
    localparam logic [2:0] ERR_CAP  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_CHECK = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic logic [7:0] sq_base(input logic [5:0] idx);
        return {2'b00, idx} * 8'd3;
    endfunction

    function automatic logic [2:0] sq_get(input logic [191:0] b, input logic [5:0] idx);
        return b[sq_base(idx) +: 3];
    endfunction

    function automatic logic is_p1_piece(input logic [2:0] code);
        return (code == SQ_P1_MAN) || (code == SQ_P1_KING);
    endfunction

    function automatic logic is_p2_piece(input logic [2:0] code);
        return (code == SQ_P2_MAN) || (code == SQ_P2_KING);
    endfunction

    // Dark squares have odd row+col, i.e. row[0] differs from col[0]
    function automatic logic [191:0] init_board_f();
        logic [191:0] b;
        logic [5:0]   idx;
        logic [2:0]   code;
        b = '0;
        for (int i = 0; i < 64; i++) begin
            idx = i[5:0];
            if ((idx[3] ^ idx[0]) == 1'b0) begin
                code = SQ_LIGHT;
            end else if (idx[5:3] < 3'd3) begin
                code = SQ_P1_MAN;
            end else if (idx[5:3] > 3'd4) begin
                code = SQ_P2_MAN;
            end else begin
                code = SQ_EMPTY;
            end
            b[sq_base(idx) +: 3] = code;
        end
        return b;
    endfunction

    localparam logic [191:0] INIT_BOARD = init_board_f();

endpackage

// File: rtl/checkers_move_rules.sv
// Combinational move legality: ownership, destination, geometry and capture
// checks in priority order, plus jump detection and king promotion.
module checkers_move_rules
    import checkers_pkg::*;
(
    input  logic [2:0] from_code,
    input  logic [2:0] to_code,
    input  logic [2:0] mid_code,
    input  logic [5:0] from_sq,
    input  logic [5:0] to_sq,
    input  logic       turn,
    output logic [2:0] err,
    output logic       jump,
    output logic [2:0] dest_code
);

    logic [3:0] dr_s;
    logic [3:0] dc_s;
    logic [3:0] adr_s;
    logic [3:0] adc_s;
    logic       own_s;
    logic       opp_mid_s;
    logic       fwd_s;
    logic       dir_ok_s;
    logic       step_s;
    logic       hop_s;

    // 4-bit two's-complement row/column deltas, so wrap-around never looks diagonal
    assign dr_s = {1'b0, to_sq[5:3]} - {1'b0, from_sq[5:3]};
    assign dc_s = {1'b0, to_sq[2:0]} - {1'b0, from_sq[2:0]};

    // Geometry and ownership classification of the request
    always_comb begin
        adr_s     = dr_s[3] ? (4'd0 - dr_s) : dr_s;
        adc_s     = dc_s[3] ? (4'd0 - dc_s) : dc_s;
        own_s     = turn ? is_p2_piece(from_code) : is_p1_piece(from_code);
        opp_mid_s = turn ? is_p1_piece(mid_code) : is_p2_piece(mid_code);
        fwd_s     = turn ? dr_s[3] : (!dr_s[3] && (dr_s != 4'd0));
        dir_ok_s  = from_code[2] | fwd_s;
        step_s    = (adr_s == 4'd1) && (adc_s == 4'd1);
        hop_s     = (adr_s == 4'd2) && (adc_s == 4'd2);
    end

    // First failing check wins; promotion applies only to men reaching the far row
    always_comb begin
        if (!own_s) begin
            err = ERR_SRC;
        end else if (to_code != SQ_EMPTY) begin
            err = ERR_DST;
        end else if (!(step_s || hop_s) || !dir_ok_s) begin
            err = ERR_GEOM;
        end else if (hop_s && !opp_mid_s) begin
            err = ERR_CAP;
        end else begin
            err = ERR_OK;
        end
        jump = hop_s;
        if ((from_code == SQ_P1_MAN) && (to_sq[5:3] == 3'd7)) begin
            dest_code = SQ_P1_KING;
        end else if ((from_code == SQ_P2_MAN) && (to_sq[5:3] == 3'd0)) begin
            dest_code = SQ_P2_KING;
        end else begin
            dest_code = from_code;
        end
    end

endmodule

// File: rtl/checkers_board_state.sv
// Board and turn owner: accepts one from/to move at a time, validates it in a
// fixed five-state sequence and publishes the packed board to the drawer.
module checkers_board_state
    import checkers_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         new_game,
    input  logic         move_valid,
    output logic         move_ready,
    input  logic [5:0]   move_from,
    input  logic [5:0]   move_to,
    output logic         move_done,
    output logic         move_ok,
    output logic [2:0]   move_err,
    output logic         turn,
    output logic [191:0] board,
    output logic         board_update
);

    state_t       state_r;
    logic [5:0]   from_r;
    logic [5:0]   to_r;
    logic [5:0]   mid_r;
    logic [2:0]   from_code_r;
    logic [2:0]   to_code_r;
    logic [2:0]   mid_code_r;
    logic [2:0]   err_r;
    logic         jump_r;
    logic [2:0]   dest_code_r;
    logic [191:0] board_r;
    logic         turn_r;
    logic         ready_r;
    logic         done_r;
    logic         ok_r;
    logic [2:0]   err_out_r;
    logic         upd_r;
    logic [5:0]   mid_sq_s;
    logic [2:0]   rule_err_s;
    logic         rule_jump_s;
    logic [2:0]   rule_dest_s;

    // Index average lands on the jumped square whenever the move is a two-step diagonal
    assign mid_sq_s = 6'(({1'b0, move_from} + {1'b0, move_to}) >> 7'd1);

    checkers_move_rules u_rules (
        .from_code (from_code_r),
        .to_code   (to_code_r),
        .mid_code  (mid_code_r),
        .from_sq   (from_r),
        .to_sq     (to_r),
        .turn      (turn_r),
        .err       (rule_err_s),
        .jump      (rule_jump_s),
        .dest_code (rule_dest_s)
    );

    // Move FSM with board, turn and all handshake outputs held in registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            from_r      <= 6'd0;
            to_r        <= 6'd0;
            mid_r       <= 6'd0;
            from_code_r <= SQ_LIGHT;
            to_code_r   <= SQ_LIGHT;
            mid_code_r  <= SQ_LIGHT;
            err_r       <= ERR_OK;
            jump_r      <= 1'b0;
            dest_code_r <= SQ_LIGHT;
            board_r     <= INIT_BOARD;
            turn_r      <= 1'b0;
            ready_r     <= 1'b1;
            done_r      <= 1'b0;
            ok_r        <= 1'b0;
            err_out_r   <= ERR_OK;
            upd_r       <= 1'b0;
        end else if (new_game) begin
            state_r <= ST_IDLE;
            board_r <= INIT_BOARD;
            turn_r  <= 1'b0;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
            upd_r   <= 1'b1;
        end else begin
            done_r <= 1'b0;
            upd_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (move_valid) begin
                        from_r  <= move_from;
                        to_r    <= move_to;
                        mid_r   <= mid_sq_s;
                        ready_r <= 1'b0;
                        state_r <= ST_READ;
                    end
                end
                ST_READ: begin
                    from_code_r <= sq_get(board_r, from_r);
                    to_code_r   <= sq_get(board_r, to_r);
                    mid_code_r  <= sq_get(board_r, mid_r);
                    state_r     <= ST_CHECK;
                end
                ST_CHECK: begin
                    err_r       <= rule_err_s;
                    jump_r      <= rule_jump_s;
                    dest_code_r <= rule_dest_s;
                    state_r     <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (err_r == ERR_OK) begin
                        board_r[sq_base(from_r) +: 3] <= SQ_EMPTY;
                        if (jump_r) begin
                            board_r[sq_base(mid_r) +: 3] <= SQ_EMPTY;
                        end
                        board_r[sq_base(to_r) +: 3] <= dest_code_r;
                        turn_r <= ~turn_r;
                        upd_r  <= 1'b1;
                    end
                    ok_r      <= (err_r == ERR_OK);
                    err_out_r <= err_r;
                    done_r    <= 1'b1;
                    state_r   <= ST_DONE;
                end
                ST_DONE: begin
                    ready_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    ready_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign move_ready   = ready_r;
    assign move_done    = done_r;
    assign move_ok      = ok_r;
    assign move_err     = err_out_r;
    assign turn         = turn_r;
    assign board        = board_r;
    assign board_update = upd_r;

endmodule

// File: tb/tb_checkers_board_state.sv
// Scoreboard bench for checkers_board_state: each move pushes its expected
// result, which is popped and compared when move_done appears.
module tb_checkers_board_state;

    logic         clk = 1'b0;
    logic         rst;
    logic         new_game;
    logic         move_valid;
    logic         move_ready;
    logic [5:0]   move_from;
    logic [5:0]   move_to;
    logic         move_done;
    logic         move_ok;
    logic [2:0]   move_err;
    logic         turn;
    logic [191:0] board;
    logic         board_update;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic         ok;
        logic [2:0]   err;
        logic [191:0] brd;
        logic         trn;
    } exp_t;

    exp_t         sb[$];
    logic [191:0] exp_board;
    logic         exp_turn;
    logic [191:0] init_b;

    checkers_board_state dut (
        .clk          (clk),
        .rst          (rst),
        .new_game     (new_game),
        .move_valid   (move_valid),
        .move_ready   (move_ready),
        .move_from    (move_from),
        .move_to      (move_to),
        .move_done    (move_done),
        .move_ok      (move_ok),
        .move_err     (move_err),
        .turn         (turn),
        .board        (board),
        .board_update (board_update)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] sq(input logic [191:0] b, input int i);
        return b[i*3 +: 3];
    endfunction

    function automatic logic [191:0] put(input logic [191:0] b, input int i, input logic [2:0] c);
        logic [191:0] r;
        r = b;
        r[i*3 +: 3] = c;
        return r;
    endfunction

    function automatic logic [191:0] init_layout();
        logic [191:0] b;
        b = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (((r + c) % 2) == 1) begin
                    if (r <= 2)      b[(r*8+c)*3 +: 3] = 3'b001;
                    else if (r >= 5) b[(r*8+c)*3 +: 3] = 3'b010;
                    else             b[(r*8+c)*3 +: 3] = 3'b111;
                end
            end
        end
        return b;
    endfunction

    task automatic do_move(input int f, input int t, input logic eok, input logic [2:0] eerr,
                           input logic [191:0] eb, input logic etrn);
        exp_t e;
        int   lat;
        e.ok = eok; e.err = eerr; e.brd = eb; e.trn = etrn;
        sb.push_back(e);
        move_from  = 6'(f);
        move_to    = 6'(t);
        move_valid = 1'b1;
        tests_run++;
        if (move_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL ready_before %0d->%0d: got %b want 1", f, t, move_ready);
        end
        @(negedge clk);
        move_valid = 1'b0;
        lat = 1;
        while (move_done !== 1'b1 && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        tests_run++;
        if (move_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL done_timeout %0d->%0d: got no move_done want pulse", f, t);
            void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            if (lat !== 4) begin
                tests_failed++;
                $display("FAIL latency %0d->%0d: got %0d want 4", f, t, lat);
            end
            tests_run++;
            if (move_ok !== e.ok || move_err !== e.err) begin
                tests_failed++;
                $display("FAIL result %0d->%0d: got ok=%b err=%0d want ok=%b err=%0d",
                         f, t, move_ok, move_err, e.ok, e.err);
            end
            tests_run++;
            if (board !== e.brd) begin
                tests_failed++;
                $display("FAIL board %0d->%0d: got %h want %h", f, t, board, e.brd);
            end
            tests_run++;
            if (turn !== e.trn || board_update !== e.ok) begin
                tests_failed++;
                $display("FAIL turn_upd %0d->%0d: got turn=%b upd=%b want turn=%b upd=%b",
                         f, t, turn, board_update, e.trn, e.ok);
            end
        end
        exp_board = eb;
        exp_turn  = etrn;
        @(negedge clk);
        tests_run++;
        if (move_done !== 1'b0 || move_ready !== 1'b1 || board_update !== 1'b0) begin
            tests_failed++;
            $display("FAIL after_done %0d->%0d: got done=%b ready=%b upd=%b want 0 1 0",
                     f, t, move_done, move_ready, board_update);
        end
    endtask

    task automatic step(input int f, input int t, input logic [2:0] code);
        do_move(f, t, 1'b1, 3'd0, put(put(exp_board, f, 3'b111), t, code), ~exp_turn);
    endtask

    task automatic jump(input int f, input int t, input int m, input logic [2:0] code);
        do_move(f, t, 1'b1, 3'd0, put(put(put(exp_board, f, 3'b111), m, 3'b111), t, code), ~exp_turn);
    endtask

    task automatic bad(input int f, input int t, input logic [2:0] err);
        do_move(f, t, 1'b0, err, exp_board, exp_turn);
    endtask

    task automatic watch_no_done(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (move_done === 1'b1) seen++;
        end
        tests_run++;
        if (seen != 0) begin
            tests_failed++;
            $display("FAIL %s: got %0d move_done pulses want 0", name, seen);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; new_game = 1'b0; move_valid = 1'b0; move_from = 6'd0; move_to = 6'd0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (board !== init_b) begin
            tests_failed++;
            $display("FAIL reset_board: got %h want %h", board, init_b);
        end
        tests_run++;
        if (turn !== 1'b0 || move_ready !== 1'b1 || move_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got turn=%b ready=%b done=%b want 0 1 0", turn, move_ready, move_done);
        end
        tests_run++;
        if (move_ok !== 1'b0 || move_err !== 3'd0 || board_update !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_status: got ok=%b err=%0d upd=%b want 0 0 0", move_ok, move_err, board_update);
        end
        tests_run++;
        if (sq(board, 17) !== 3'b001 || sq(board, 24) !== 3'b111) begin
            tests_failed++;
            $display("FAIL reset_squares: got sq17=%b sq24=%b want 001 111", sq(board, 17), sq(board, 24));
        end
        exp_board = init_b;
        exp_turn  = 1'b0;
    endtask

    task automatic test_simple_move();
        step(17, 24, 3'b001);
    endtask

    task automatic test_capture();
        step(40, 33, 3'b010);
        bad(24, 33, 3'd2);
        step(23, 30, 3'b001);
        step(42, 35, 3'b010);
        tests_run++;
        if (sq(board, 33) !== 3'b010 || sq(board, 42) !== 3'b111) begin
            tests_failed++;
            $display("FAIL pre_jump: got sq33=%b sq42=%b want 010 111", sq(board, 33), sq(board, 42));
        end
        jump(24, 42, 33, 3'b001);
        tests_run++;
        if (sq(board, 33) !== 3'b111 || sq(board, 42) !== 3'b001) begin
            tests_failed++;
            $display("FAIL post_jump: got sq33=%b sq42=%b want 111 001", sq(board, 33), sq(board, 42));
        end
    endtask

    task automatic test_errors();
        bad(17, 24, 3'd1);
        bad(42, 33, 3'd1);
        step(46, 39, 3'b010);
        bad(42, 33, 3'd3);
        bad(19, 27, 3'd2);
        bad(19, 37, 3'd4);
    endtask

    task automatic test_promotion();
        step(19, 26, 3'b001);
        step(53, 46, 3'b010);
        step(21, 28, 3'b001);
        step(60, 53, 3'b010);
        jump(42, 60, 51, 3'b101);
        step(44, 37, 3'b010);
        step(60, 51, 3'b101);
    endtask

    task automatic test_new_game();
        move_from = 6'd49; move_to = 6'd42; move_valid = 1'b1; new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0; move_valid = 1'b0;
        tests_run++;
        if (board !== init_b || turn !== 1'b0 || move_ready !== 1'b1 || board_update !== 1'b1) begin
            tests_failed++;
            $display("FAIL ng_idle: got turn=%b ready=%b upd=%b board_ok=%b want 0 1 1 1",
                     turn, move_ready, board_update, board === init_b);
        end
        exp_board = init_b;
        exp_turn  = 1'b0;
        watch_no_done("ng_idle_no_accept", 8);
        step(17, 24, 3'b001);
        move_from = 6'd40; move_to = 6'd33; move_valid = 1'b1;
        @(negedge clk);
        move_valid = 1'b0;
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        tests_run++;
        if (board !== init_b || turn !== 1'b0) begin
            tests_failed++;
            $display("FAIL ng_abort_board: got turn=%b board=%h want turn=0 board=%h", turn, board, init_b);
        end
        tests_run++;
        if (move_ready !== 1'b1 || board_update !== 1'b1 || move_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL ng_abort_ctrl: got ready=%b upd=%b done=%b want 1 1 0",
                     move_ready, board_update, move_done);
        end
        exp_board = init_b;
        exp_turn  = 1'b0;
        watch_no_done("ng_abort_no_done", 8);
    endtask

    task automatic test_reset_mid_write();
        step(17, 24, 3'b001);
        move_from = 6'd40; move_to = 6'd33; move_valid = 1'b1;
        @(negedge clk);
        move_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++;
        if (board !== init_b || turn !== 1'b0 || move_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_write_state: got turn=%b ready=%b board=%h want 0 1 %h",
                     turn, move_ready, board, init_b);
        end
        tests_run++;
        if (move_done !== 1'b0 || move_ok !== 1'b0 || move_err !== 3'd0 || board_update !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_write_status: got done=%b ok=%b err=%0d upd=%b want 0 0 0 0",
                     move_done, move_ok, move_err, board_update);
        end
        @(negedge clk);
        rst = 1'b1;
        exp_board = init_b;
        exp_turn  = 1'b0;
        watch_no_done("rst_no_done", 8);
    endtask

    task automatic test_back_to_back();
        step(17, 24, 3'b001);
        step(40, 33, 3'b010);
        bad(24, 33, 3'd2);
    endtask

    initial begin
        init_b = init_layout();
        test_reset();
        test_simple_move();
        test_capture();
        test_errors();
        test_promotion();
        test_new_game();
        test_reset_mid_write();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
